// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF fetch port and the MEM load/store port.
// Define MEMARB_PERF_EN to add the stall/conflict performance counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_cancel,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem,
`ifdef MEMARB_PERF_EN
    output logic [31:0]         cnt_if_stall,
    output logic [31:0]         cnt_mem_stall,
    output logic [31:0]         cnt_conflict,
`endif
    output logic                err
);

    typedef enum logic [1:0] {StIdle, StDAcc, StIAcc, StIDrop} state_e;

    state_e                state_q, state_d;
    logic [15:0]           tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic [16:0]           tmo_inc;
    logic                  tmo_hit;

    assign tmo_inc = {1'b0, tmo_q} + 17'd1;
    assign tmo_hit = {15'd0, tmo_inc} >= TIMEOUT_CYC;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        if_valid = 1'b0;
        d_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                // Data wins: the MEM-stage instruction is older than the fetch.
                if (d_req) begin
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wmask_d = d_wmask;
                    state_d = StDAcc;
                end else if (if_req && !if_cancel) begin
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = StIAcc;
                end
            end
            StDAcc: begin
                if (mem_ack) begin
                    d_valid = 1'b1;
                    state_d = StIdle;
                end
            end
            StIAcc: begin
                if (mem_ack) begin
                    if_valid = !if_cancel;
                    state_d  = StIdle;
                end else if (if_cancel) begin
                    state_d = StIDrop;
                end
            end
            StIDrop: begin
                if (mem_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort a hung access; the requester keeps its req and is re-granted from idle.
        if (state_q != StIdle && !mem_ack) begin
            if (tmo_hit) begin
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign mem_req   = (state_q != StIdle);
    assign mem_we    = (state_q == StDAcc) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign stall_if  = if_req && !if_valid && !if_cancel;
    assign stall_mem = d_req && !d_valid;
    assign err       = err_q;

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_if_stall  <= '0;
            cnt_mem_stall <= '0;
            cnt_conflict  <= '0;
        end else begin
            if (stall_if)  cnt_if_stall  <= cnt_if_stall + 32'd1;
            if (stall_mem) cnt_mem_stall <= cnt_mem_stall + 32'd1;
            if (state_q == StIdle && d_req && if_req) cnt_conflict <= cnt_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_cancel = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        if_valid, d_valid, mem_req, mem_we, stall_if, stall_mem, err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
`ifdef MEMARB_PERF_EN
    logic [31:0] cnt_if_stall, cnt_mem_stall, cnt_conflict;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef MEMARB_PERF_EN
        .cnt_if_stall(cnt_if_stall), .cnt_mem_stall(cnt_mem_stall), .cnt_conflict(cnt_conflict),
`endif
        .err(err)
    );

    int tests = 0;
    int fails = 0;

    // Memory responder: acks lat_cfg cycles after mem_req rises.
    int  lat_cfg = 2;
    bit  ack_en = 1'b1;
    bit  stray = 1'b0;
    bit  prev_req = 1'b0;
    int  age = 0;
    logic [31:0] dut_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) age = prev_req ? age + 1 : 0;
            else age = 0;
            prev_req  = mem_req;
            mem_ack   = stray || (mem_req && ack_en && age == lat_cfg);
            mem_rdata = dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : init_word(mem_addr);
            if (mem_ack && mem_req && mem_we)
                dut_mem[mem_addr] = merge(mem_rdata, mem_wdata, mem_wmask);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One isolated access; valid is due lat+1 cycles after the request.
    task automatic do_single(input bit is_d, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] m, input int lat);
        int          done = lat + 1;
        bit          st = is_d && we;
        logic [31:0] exp = ref_rd(a);
        lat_cfg = lat;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wmask = m;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int c = 0; c <= done; c++) begin
            #1;
            chk1("single.mem_req", mem_req, c >= 1);
            if (c >= 1) begin
                chk32("single.mem_addr", mem_addr, a);
                chk1("single.mem_we", mem_we, st);
                if (st) begin
                    chk32("single.mem_wdata", mem_wdata, wd);
                    chk32("single.mem_wmask", {28'd0, mem_wmask}, {28'd0, m});
                end
            end
            chk1("single.d_valid", d_valid, is_d && c == done);
            chk1("single.if_valid", if_valid, !is_d && c == done);
            if (is_d) chk1("single.stall_mem", stall_mem, c < done);
            else      chk1("single.stall_if", stall_if, c < done);
            if (c == done && !st) chk32("single.rdata", is_d ? d_rdata : if_rdata, exp);
            cyc();
            if (c == done) begin
                d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
                if (st) ref_mem[a] = merge(exp, wd, m);
            end
        end
    endtask

    // Load and fetch requested together: load first, one idle cycle, then the fetch.
    task automatic conflict(input logic [31:0] da, input logic [31:0] ia, input int ld,
                            input int lf);
        int dd = 1 + ld;
        int fd = 3 + ld + lf;
`ifdef MEMARB_PERF_EN
        logic [31:0] c0 = cnt_conflict, m0 = cnt_mem_stall, i0 = cnt_if_stall;
`endif
        lat_cfg = ld;
        d_req = 1'b1; d_we = 1'b0; d_addr = da; if_req = 1'b1; if_addr = ia;
        for (int c = 0; c <= fd; c++) begin
            if (c == 2 + ld) lat_cfg = lf;
            #1;
            chk1("conf.mem_req", mem_req, c >= 1 && c != 2 + ld);
            if (c >= 1 && c <= dd) chk32("conf.d_addr", mem_addr, da);
            if (c >= 3 + ld) chk32("conf.i_addr", mem_addr, ia);
            if (c >= 1) chk1("conf.mem_we", mem_we, 1'b0);
            chk1("conf.d_valid", d_valid, c == dd);
            chk1("conf.if_valid", if_valid, c == fd);
            chk1("conf.stall_mem", stall_mem, c < dd);
            chk1("conf.stall_if", stall_if, c < fd);
            if (c == dd) chk32("conf.d_rdata", d_rdata, ref_rd(da));
            if (c == fd) chk32("conf.if_rdata", if_rdata, ref_rd(ia));
            cyc();
            if (c == dd) d_req = 1'b0;
            if (c == fd) if_req = 1'b0;
        end
`ifdef MEMARB_PERF_EN
        chk32("perf.conflict", cnt_conflict - c0, 32'd1);
        chk32("perf.mem_stall", cnt_mem_stall - m0, 32'(dd));
        chk32("perf.if_stall", cnt_if_stall - i0, 32'(fd));
`endif
    endtask

    initial begin
        int          kind;
        logic [31:0] a, b;
        dut_mem[32'h100] = 32'h0050_0093;
        ref_mem[32'h100] = 32'h0050_0093;

        // Reset state
        cyc(); cyc(); #1;
        chk1("rst.mem_req", mem_req, 1'b0);
        chk1("rst.mem_we", mem_we, 1'b0);
        chk32("rst.mem_addr", mem_addr, 32'h0);
        chk32("rst.mem_wdata", mem_wdata, 32'h0);
        chk32("rst.mem_wmask", {28'd0, mem_wmask}, 32'h0);
        chk1("rst.if_valid", if_valid, 1'b0);
        chk1("rst.d_valid", d_valid, 1'b0);
        chk1("rst.err", err, 1'b0);
        rst = 1'b0;
        cyc();

        // Fetch, store, load-back, conflict
        do_single(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 2);
        do_single(1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011, 3);
        do_single(1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 2);
        conflict(32'h2000, 32'h104, 2, 2);

        // Flush: cancel one cycle after the grant, ack three cycles later, then new fetch
        lat_cfg = 3;
        if_req = 1'b1; if_addr = 32'h180;
        for (int c = 0; c <= 9; c++) begin
            if (c == 1) begin if_cancel = 1'b1; if_req = 1'b0; end
            if (c == 2) begin if_cancel = 1'b0; if_req = 1'b1; if_addr = 32'h200; end
            #1;
            chk1("flush.mem_req", mem_req, c >= 1 && c != 5);
            if (c >= 1 && c <= 4) chk32("flush.addr0", mem_addr, 32'h180);
            if (c >= 6) chk32("flush.addr1", mem_addr, 32'h200);
            chk1("flush.if_valid", if_valid, c == 9);
            chk1("flush.stall_if", stall_if, c != 1 && c < 9);
            if (c == 9) chk32("flush.if_rdata", if_rdata, ref_rd(32'h200));
            cyc();
        end
        if_req = 1'b0;

        // Cancel in the same cycle as the ack: no valid, straight back to idle
        lat_cfg = 2;
        if_req = 1'b1; if_addr = 32'h1C0;
        for (int c = 0; c <= 4; c++) begin
            if (c == 3) if_cancel = 1'b1;
            if (c == 4) begin if_cancel = 1'b0; if_req = 1'b0; end
            #1;
            chk1("cack.mem_req", mem_req, c >= 1 && c <= 3);
            chk1("cack.if_valid", if_valid, 1'b0);
            chk1("cack.stall_if", stall_if, c < 3);
            cyc();
        end

        // Randomized single accesses and conflicts
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            a = 32'h4000 + 32'($urandom_range(0, 7)) * 4;
            b = 32'h4000 + 32'($urandom_range(0, 7)) * 4;
            case (kind)
                0: do_single(1'b0, 1'b0, a, 32'h0, 4'h0, int'($urandom_range(1, 4)));
                1: do_single(1'b1, 1'b0, a, 32'h0, 4'h0, int'($urandom_range(1, 4)));
                2: do_single(1'b1, 1'b1, a, $urandom, 4'($urandom_range(1, 15)),
                             int'($urandom_range(1, 4)));
                default: conflict(a, b, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            endcase
        end

        // Timeout: no ack ever; abort after 8 busy cycles, err sticks, load is re-granted
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        for (int c = 0; c <= 12; c++) begin
            #1;
            chk1("tmo.mem_req", mem_req, c >= 1 && c != 9);
            chk1("tmo.err", err, c >= 9);
            chk1("tmo.d_valid", d_valid, 1'b0);
            chk1("tmo.stall_mem", stall_mem, 1'b1);
            cyc();
        end
        // Reset mid-access
        rst = 1'b1; d_req = 1'b0;
        cyc(); #1;
        chk1("tmo.rst_err", err, 1'b0);
        chk1("tmo.rst_mem_req", mem_req, 1'b0);
        chk1("tmo.rst_mem_we", mem_we, 1'b0);
        chk32("tmo.rst_mem_addr", mem_addr, 32'h0);
        chk32("tmo.rst_mem_wdata", mem_wdata, 32'h0);
        chk32("tmo.rst_mem_wmask", {28'd0, mem_wmask}, 32'h0);
        rst = 1'b0; ack_en = 1'b1;
        // Stray ack while idle is ignored
        stray = 1'b1;
        cyc(); #1;
        chk1("stray.d_valid", d_valid, 1'b0);
        chk1("stray.if_valid", if_valid, 1'b0);
        chk1("stray.mem_req", mem_req, 1'b0);
        stray = 1'b0;
        cyc(); #1;
        chk1("stray.mem_req_after", mem_req, 1'b0);
        chk1("stray.err", err, 1'b0);
        cyc();

        // Normal traffic after all of the above
        do_single(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one shared single-ported instruction/data memory between two requesters in the 5-stage pipeline: the IF stage (fetch, read-only) and the MEM stage (load/store).
- Allows only one memory access to be outstanding at a time.
- Drives stall_if and stall_mem into the hazard detection unit, so PC/IF-ID freeze on fetch waits and the whole pipeline freezes on data waits.
- Drops fetches that are cancelled by a branch flush.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.
- TIMEOUT_CYC, 255, maximum cycles one access may wait for mem_ack before abort; 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_valid or if_cancel.
- if_addr  in  ADDR_W  fetch address.
- if_cancel  in  1  branch flush; kills the pending or in-flight fetch.
- if_valid  out  1  fetch done; combinational.
- if_rdata  out  DATA_W  instruction word; meaningful only while if_valid=1.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wmask until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  byte enables.
- d_valid  out  1  data access done; combinational.
- d_rdata  out  DATA_W  load data; meaningful only while d_valid=1.
- mem_req  out  1  memory access active.
- mem_we  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  equals if_req & ~if_valid & ~if_cancel.
- stall_mem  out  1  equals d_req & ~d_valid.
- err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, D_ACC, I_ACC, I_DROP. Reset puts the FSM in IDLE and clears err, the timeout counter and the latched address/attribute registers.
- Reset values: all mem_* outputs and both valids are 0. Reset mid-access abandons the access; a later stray mem_ack is ignored.
- IDLE arbitration, evaluated every cycle:
  - d_req=1: latch the data attributes and go to D_ACC. Data has fixed priority because the MEM-stage instruction is older.
  - Else if_req=1 & ~if_cancel: latch if_addr and go to I_ACC.
  - Else stay in IDLE.
- Memory-side outputs:
  - mem_req = (state != IDLE).
  - mem_addr/mem_wdata/mem_wmask come from the latched registers and are stable for the whole access.
  - mem_we = latched d_we in D_ACC, otherwise 0.
- D_ACC:
  - On mem_ack: d_valid=1 and d_rdata=mem_rdata in the same cycle; next state IDLE.
  - Store completions also pulse d_valid; d_rdata is don't-care for stores.
- I_ACC:
  - mem_ack & ~if_cancel: if_valid=1, if_rdata=mem_rdata; next state IDLE.
  - mem_ack & if_cancel: if_valid suppressed; next state IDLE.
  - if_cancel without mem_ack: next state I_DROP.
- I_DROP: wait for mem_ack, discard the data, go to IDLE. if_valid is never asserted in I_DROP.
- Latency: one arbitration cycle in IDLE plus the memory latency. With mem_ack N cycles after mem_req rises, the request-to-valid time is N+1 cycles.
- Back-to-back accesses always pass through one IDLE cycle.
- A requester's req may already be its next request in the cycle after its valid.
- Simultaneous d_req and if_req in IDLE: data is served first, and the fetch stays stalled until its own completion.
- A new if_req arriving while in I_DROP waits; it is granted from IDLE.
- Timeout:
  - A 16-bit counter clears on entry to any non-IDLE state and increments each non-IDLE cycle without mem_ack.
  - When the counter reaches TIMEOUT_CYC: set err (sticky until rst), go to IDLE, assert no valid. The requester remains stalled.
- mem_ack in IDLE is ignored.

Optional Feature:
- Macro MEMARB_PERF_EN.
- Defined: adds three outputs, each 32 bits and wrapping at 2^32-1, all cleared by rst:
  - cnt_if_stall: increments each cycle stall_if=1.
  - cnt_mem_stall: increments each cycle stall_mem=1.
  - cnt_conflict: increments each IDLE cycle with d_req=1 & if_req=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req with 0x00500093. Required: mem_req rises cycle 1; if_valid=1 with if_rdata=0x00500093 at cycle 3; stall_if high cycles 0-2.
- Conflict: d_req load from 0x2000 and if_req from 0x104 in the same cycle. Required: the data access goes first (mem_addr=0x2000, mem_we=0); d_valid precedes any if_valid; one IDLE cycle, then mem_addr=0x104.
- Store: d_we=1, d_addr=0x3000, d_wdata=0xDEADBEEF, d_wmask=4'b0011. Required: mem_we=1 with these exact values, held stable until mem_ack; d_valid=1 on mem_ack.
- Flush: if_cancel pulses 1 cycle after the fetch is granted, with ack 3 cycles later. Required: FSM goes I_ACC→I_DROP→IDLE; if_valid never asserted; the next if_req from 0x200 is granted after IDLE.
- Timeout: TIMEOUT_CYC=8, mem_ack never arrives. Required: err=1 after 8 non-IDLE cycles, FSM returns to IDLE, err stays 1 until rst; rst then clears err and the mem_* outputs to 0.
- Perf (MEMARB_PERF_EN defined): rerun the conflict scenario. Required: cnt_conflict=1 and cnt_mem_stall equal to the counted stall cycles (3 with 2-cycle ack).
